// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a LEN-word burst from a registered-read FIFO onto a valid/ready stream
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  word_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [LEN_WIDTH-1:0] ONE = 1;
  state_t state, state_nxt;
  logic [LEN_WIDTH-1:0] len_q, issue_cnt;
  logic inflight, inflight_last, l0, l1, pop, last_issue, wr_hi;
  logic [1:0] occ;
  logic [DATA_WIDTH-1:0] d1;
  // m_data doubles as the buffer head; d1/l1 is the second slot
  always_comb begin
    m_valid = occ != 2'd0;
    m_last = m_valid & l0;
    busy = state != IDLE;
    pop = m_valid & m_ready;
    last_issue = issue_cnt == len_q - ONE;
    wr_hi = (occ - {1'b0, pop}) != 2'd0;
    fifo_rd_en = (state == RUN) & !fifo_empty &
                 (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    state_nxt = (state == IDLE && start && len != '0) ? RUN :
                (state == RUN && fifo_rd_en && last_issue) ? DRAIN :
                (state == DRAIN && pop && m_last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      len_q <= '0;
      issue_cnt <= '0;
      word_cnt <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      occ <= '0;
      m_data <= '0;
      l0 <= 1'b0;
      d1 <= '0;
      l1 <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      inflight <= fifo_rd_en;
      inflight_last <= fifo_rd_en & last_issue;
      done <= (state == IDLE && start && len == '0) || (state == DRAIN && pop && m_last);
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
      if (pop) begin
        m_data <= d1;
        l0 <= l1;
      end
      // read data lands in the first free slot after this cycle's pop
      if (inflight && wr_hi) begin
        d1 <= fifo_data_out;
        l1 <= inflight_last;
      end
      if (inflight && !wr_hi) begin
        m_data <= fifo_data_out;
        l0 <= inflight_last;
      end
      if (state == IDLE && start) begin
        len_q <= len;
        issue_cnt <= '0;
        word_cnt <= '0;
      end else begin
        if (fifo_rd_en) issue_cnt <= issue_cnt + ONE;
        if (pop && word_cnt != len_q) word_cnt <= word_cnt + ONE;
      end
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed scenarios against a behavioural registered-read FIFO
module tb_fifo_burst_reader;
  localparam int DW = 32;
  localparam int LW = 8;
  logic clk = 0, reset = 1, start = 0, m_ready = 0;
  logic [LW-1:0] len = '0;
  logic fifo_empty, fifo_rd_en, m_valid, m_last, busy, done;
  logic [DW-1:0] fifo_data_out = '0;
  logic [DW-1:0] m_data;
  logic [LW-1:0] word_cnt;
  logic [DW-1:0] mem [16];
  int wp = 0, rp = 0;
  int total = 0, bad = 0;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy), .done(done),
    .word_cnt(word_cnt));

  always #5 clk = ~clk;
  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (fifo_rd_en && wp != rp) begin
      fifo_data_out <= mem[rp % 16];
      rp <= rp + 1;
    end else fifo_data_out <= '0;
  end

  task push(input logic [DW-1:0] d);
    mem[wp % 16] = d;
    wp = wp + 1;
  endtask

  task test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
    total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%0b exp=0", m_last); end
    total++; if (m_data !== '0) begin bad++; $display("FAIL reset_m_data got=%0h exp=0", m_data); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (word_cnt !== '0) begin bad++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%0b exp=0", fifo_rd_en); end
    reset = 0;
  endtask

  task test_basic;
    logic ev, er;
    for (int i = 0; i < 4; i++) push(DW'(32'hA0 + i));
    @(negedge clk);
    start = 1; len = 4; m_ready = 1;
    #1;
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL basic_rd_en_c0 got=%0b exp=0", fifo_rd_en); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 0;
      #1;
      er = (c >= 1 && c <= 4);
      ev = (c >= 3 && c <= 6);
      total++; if (fifo_rd_en !== er) begin bad++; $display("FAIL basic_rd_en c=%0d got=%0b exp=%0b", c, fifo_rd_en, er); end
      total++; if (m_valid !== ev) begin bad++; $display("FAIL basic_m_valid c=%0d got=%0b exp=%0b", c, m_valid, ev); end
      if (ev) begin
        total++; if (m_data !== DW'(32'hA0 + c - 3)) begin bad++; $display("FAIL basic_m_data c=%0d got=%0h exp=%0h", c, m_data, 32'hA0 + c - 3); end
      end
      total++; if (m_last !== (c == 6)) begin bad++; $display("FAIL basic_m_last c=%0d got=%0b exp=%0b", c, m_last, c == 6); end
      total++; if (done !== (c == 7)) begin bad++; $display("FAIL basic_done c=%0d got=%0b exp=%0b", c, done, c == 7); end
      total++; if (busy !== (c <= 6)) begin bad++; $display("FAIL basic_busy c=%0d got=%0b exp=%0b", c, busy, c <= 6); end
      if (c == 7) begin
        total++; if (word_cnt !== LW'(4)) begin bad++; $display("FAIL basic_word_cnt got=%0d exp=4", word_cnt); end
      end
    end
  endtask

  task test_stall;
    int idx, rp0;
    logic held, hold_l, seen;
    logic [DW-1:0] hold_d;
    idx = 0; held = 0; seen = 0; hold_d = '0; hold_l = 0;
    for (int i = 0; i < 6; i++) push(DW'(32'hB0 + i));
    @(negedge clk);
    rp0 = rp;
    start = 1; len = 6; m_ready = 1;
    for (int c = 1; c < 80 && !seen; c++) begin
      @(negedge clk);
      start = 0;
      m_ready = (c % 3 == 1);
      #1;
      total++; if ((rp - rp0) - idx > 2) begin bad++; $display("FAIL stall_credit c=%0d outstanding=%0d max=2", c, (rp - rp0) - idx); end
      if (held) begin
        total++; if (m_valid !== 1'b1 || m_data !== hold_d || m_last !== hold_l) begin bad++; $display("FAIL stall_hold c=%0d got=%0b/%0h/%0b exp=1/%0h/%0b", c, m_valid, m_data, m_last, hold_d, hold_l); end
      end
      if (done) begin
        seen = 1;
        total++; if (idx !== 6) begin bad++; $display("FAIL stall_count got=%0d exp=6", idx); end
        total++; if (word_cnt !== LW'(6)) begin bad++; $display("FAIL stall_word_cnt got=%0d exp=6", word_cnt); end
      end
      if (m_valid) begin
        total++; if (m_data !== DW'(32'hB0 + idx)) begin bad++; $display("FAIL stall_data idx=%0d got=%0h exp=%0h", idx, m_data, 32'hB0 + idx); end
        total++; if (m_last !== (idx == 5)) begin bad++; $display("FAIL stall_last idx=%0d got=%0b exp=%0b", idx, m_last, idx == 5); end
        held = !m_ready; hold_d = m_data; hold_l = m_last;
        if (m_ready) idx++;
      end else held = 0;
    end
    total++; if (!seen) begin bad++; $display("FAIL stall_timeout done got=0 exp=1"); end
    total++; if (rp - rp0 !== 6) begin bad++; $display("FAIL stall_reads got=%0d exp=6", rp - rp0); end
  endtask

  task test_empty;
    int idx;
    logic seen;
    idx = 0; seen = 0;
    push(32'hC0); push(32'hC1);
    @(negedge clk);
    start = 1; len = 5; m_ready = 1;
    for (int c = 1; c < 60 && !seen; c++) begin
      @(negedge clk);
      start = 0;
      if (c == 10) for (int i = 2; i < 5; i++) push(DW'(32'hC0 + i));
      #1;
      if (fifo_empty) begin
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL empty_rd_en c=%0d got=1 exp=0", c); end
      end
      if (done) begin
        seen = 1;
        total++; if (idx !== 5) begin bad++; $display("FAIL empty_count got=%0d exp=5", idx); end
        total++; if (word_cnt !== LW'(5)) begin bad++; $display("FAIL empty_word_cnt got=%0d exp=5", word_cnt); end
      end
      if (m_valid) begin
        total++; if (m_data !== DW'(32'hC0 + idx)) begin bad++; $display("FAIL empty_data idx=%0d got=%0h exp=%0h", idx, m_data, 32'hC0 + idx); end
        total++; if (m_last !== (idx == 4)) begin bad++; $display("FAIL empty_last idx=%0d got=%0b exp=%0b", idx, m_last, idx == 4); end
        idx++;
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL empty_timeout done got=0 exp=1"); end
  endtask

  task test_zero;
    push(32'h100);
    @(negedge clk);
    start = 1; len = 0;
    #1;
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL zero_rd_en_c0 got=%0b exp=0", fifo_rd_en); end
    @(negedge clk);
    start = 0;
    #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done_c1 got=%0b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_c1 got=%0b exp=0", busy); end
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL zero_rd_en_c1 got=%0b exp=0", fifo_rd_en); end
    @(negedge clk);
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_c2 got=%0b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_c2 got=%0b exp=0", busy); end
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL zero_rd_en_c2 got=%0b exp=0", fifo_rd_en); end
  endtask

  task test_mid_reset;
    int base;
    logic hit;
    hit = 0;
    for (int i = 1; i < 8; i++) push(DW'(32'h100 + i));
    @(negedge clk);
    start = 1; len = 8; m_ready = 1;
    for (int c = 1; c < 30 && !hit; c++) begin
      @(negedge clk);
      start = 0;
      #1;
      hit = (word_cnt == LW'(2));
    end
    total++; if (!hit) begin bad++; $display("FAIL mid_timeout word_cnt got=%0d exp=2", word_cnt); end
    reset = 1;
    @(negedge clk);
    #1;
    total++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0) begin bad++; $display("FAIL mid_reset_stream got=%0b/%0b/%0h exp=0/0/0", m_valid, m_last, m_data); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || word_cnt !== '0 || fifo_rd_en !== 1'b0) begin bad++; $display("FAIL mid_reset_ctrl got=%0b/%0b/%0d/%0b exp=0/0/0/0", busy, done, word_cnt, fifo_rd_en); end
    reset = 0;
    @(negedge clk);
    base = rp;
    start = 1; len = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 0;
      #1;
      total++; if (fifo_rd_en !== (c == 1)) begin bad++; $display("FAIL mid_rd_en c=%0d got=%0b exp=%0b", c, fifo_rd_en, c == 1); end
      total++; if (m_valid !== (c == 3) || m_last !== (c == 3)) begin bad++; $display("FAIL mid_valid_last c=%0d got=%0b/%0b exp=%0b", c, m_valid, m_last, c == 3); end
      if (c == 3) begin
        total++; if (m_data !== mem[base % 16]) begin bad++; $display("FAIL mid_data got=%0h exp=%0h", m_data, mem[base % 16]); end
      end
      total++; if (done !== (c == 4)) begin bad++; $display("FAIL mid_done c=%0d got=%0b exp=%0b", c, done, c == 4); end
      if (c == 4) begin
        total++; if (word_cnt !== LW'(1)) begin bad++; $display("FAIL mid_word_cnt got=%0d exp=1", word_cnt); end
      end
    end
  endtask

  task test_ignore;
    int idx, base;
    logic seen;
    idx = 0; seen = 0;
    for (int i = 0; i < 3; i++) push(DW'(32'h200 + i));
    @(negedge clk);
    base = rp;
    start = 1; len = 3; m_ready = 1;
    for (int c = 1; c < 40 && !seen; c++) begin
      @(negedge clk);
      start = (c == 2);
      len = (c == 2) ? LW'(7) : LW'(3);
      #1;
      if (done) begin
        seen = 1;
        total++; if (idx !== 3) begin bad++; $display("FAIL ignore_count got=%0d exp=3", idx); end
        total++; if (word_cnt !== LW'(3)) begin bad++; $display("FAIL ignore_word_cnt got=%0d exp=3", word_cnt); end
      end
      if (m_valid) begin
        total++; if (m_data !== mem[(base + idx) % 16]) begin bad++; $display("FAIL ignore_data idx=%0d got=%0h exp=%0h", idx, m_data, mem[(base + idx) % 16]); end
        total++; if (m_last !== (idx == 2)) begin bad++; $display("FAIL ignore_last idx=%0d got=%0b exp=%0b", idx, m_last, idx == 2); end
        idx++;
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL ignore_timeout done got=0 exp=1"); end
    repeat (4) @(negedge clk);
    #1;
    total++; if (busy !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL ignore_idle got=%0b/%0b exp=0/0", busy, m_valid); end
    total++; if (rp - base !== 3) begin bad++; $display("FAIL ignore_reads got=%0d exp=3", rp - base); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_empty;
    test_zero;
    test_mid_reset;
    test_ignore;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
